// File: rtl/hs32_sram_arbiter_pkg.sv
// Shared types and constants for the hs32 SRAM port arbiter: FSM states, owner codes, lane masks.
// Imported by hs32_sram_lane and hs32_sram_arbiter.
package hs32_sram_arbiter_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LANES  = 4;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_WB  = 1'b1
    } owner_e;

    localparam logic [LANES-1:0] MASK_LANE0 = 4'b0001;
    localparam logic [LANES-1:0] MASK_LANE1 = 4'b0010;
    localparam logic [LANES-1:0] MASK_LANE2 = 4'b0100;
    localparam logic [LANES-1:0] MASK_LANE3 = 4'b1000;

    // Round-robin hands a tie to whoever did not own the port last; fixed priority always picks CPU.
    function automatic owner_e pick_owner(
        input logic   cpu_req,
        input logic   wb_req,
        input owner_e last_owner,
        input logic   fixed_prio
    );
        owner_e winner;
        if (cpu_req && wb_req) begin
            if (fixed_prio || (last_owner == OWN_WB)) winner = OWN_CPU;
            else                                      winner = OWN_WB;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else begin
            winner = OWN_WB;
        end
        return winner;
    endfunction

endpackage

// File: rtl/hs32_sram_lane.sv
// Byte-lane helper for the hs32 SRAM port: one-hot write mask, read byte steering
// and write byte replication across the 32-bit word.
module hs32_sram_lane
    import hs32_sram_arbiter_pkg::*;
(
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] word,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [LANES-1:0]  mask,
    output logic [BYTE_W-1:0] byte_out,
    output logic [WORD_W-1:0] word_out
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        mask     = '0;
        byte_out = '0;
        case (lane)
            2'd0: begin mask = MASK_LANE0; byte_out = word[7:0];   end
            2'd1: begin mask = MASK_LANE1; byte_out = word[15:8];  end
            2'd2: begin mask = MASK_LANE2; byte_out = word[23:16]; end
            2'd3: begin mask = MASK_LANE3; byte_out = word[31:24]; end
            default: ;
        endcase
    end

    assign word_out = {LANES{byte_in}};

endmodule

// File: rtl/hs32_sram_arbiter.sv
// Two-requester (CPU / Wishbone) arbiter for one byte-addressed port of the hs32 SRAM bank.
// Define HS32_SRAM_ARB_STATS_EN to add the stat_conf conflict counter port.
module hs32_sram_arbiter
    import hs32_sram_arbiter_pkg::*;
#(
    parameter int AW         = 10,
    parameter int FIXED_PRIO = 0
)(
    input  logic              clk,
    input  logic              rstn,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [BYTE_W-1:0] cpu_dtw,
    output logic              cpu_ack,
    output logic [BYTE_W-1:0] cpu_dtr,

    input  logic              wb_req,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [BYTE_W-1:0] wb_dtw,
    output logic              wb_ack,
    output logic [BYTE_W-1:0] wb_dtr,

    output logic              sram_we_n,
    output logic [AW-3:0]     sram_addr,
    output logic [LANES-1:0]  sram_mask,
    output logic [WORD_W-1:0] sram_dtw,
    input  logic [WORD_W-1:0] sram_dtr
`ifdef HS32_SRAM_ARB_STATS_EN
   ,output logic [STAT_W-1:0] stat_conf
`endif
);

    state_e            state;
    owner_e            last_owner;
    logic              cur_we;
    logic [1:0]        cur_lane;

    owner_e            grant;
    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [BYTE_W-1:0] sel_dtw;

    logic [1:0]        lane_sel;
    logic [LANES-1:0]  lane_mask;
    logic [BYTE_W-1:0] rd_byte;
    logic [WORD_W-1:0] wr_word;

    assign grant = pick_owner(cpu_req, wb_req, last_owner, FIXED_PRIO != 0);

    always_comb begin
        if (grant == OWN_CPU) begin
            sel_we   = cpu_we;
            sel_addr = cpu_addr;
            sel_dtw  = cpu_dtw;
        end else begin
            sel_we   = wb_we;
            sel_addr = wb_addr;
            sel_dtw  = wb_dtw;
        end
    end

    // One lane decoder serves both directions: the new request's lane in IDLE, the latched lane afterwards.
    assign lane_sel = (state == IDLE) ? sel_addr[1:0] : cur_lane;

    hs32_sram_lane u_lane (
        .lane     (lane_sel),
        .word     (sram_dtr),
        .byte_in  (sel_dtw),
        .mask     (lane_mask),
        .byte_out (rd_byte),
        .word_out (wr_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_owner <= OWN_WB;
            cur_we     <= 1'b0;
            cur_lane   <= 2'd0;
            sram_we_n  <= 1'b1;
            sram_addr  <= '0;
            sram_mask  <= '0;
            sram_dtw   <= '0;
            cpu_ack    <= 1'b0;
            wb_ack     <= 1'b0;
            cpu_dtr    <= '0;
            wb_dtr     <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
            cpu_ack <= 1'b0;
            wb_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || wb_req) begin
                        last_owner <= grant;
                        cur_we     <= sel_we;
                        cur_lane   <= sel_addr[1:0];
                        sram_addr  <= sel_addr[AW-1:2];
                        sram_mask  <= lane_mask;
                        sram_dtw   <= wr_word;
                        sram_we_n  <= ~sel_we;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    sram_we_n <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (last_owner == OWN_CPU) begin
                        cpu_ack <= 1'b1;
                        if (!cur_we) cpu_dtr <= rd_byte;
                    end else begin
                        wb_ack <= 1'b1;
                        if (!cur_we) wb_dtr <= rd_byte;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef HS32_SRAM_ARB_STATS_EN
    logic conflict;
    assign conflict = (state == IDLE) && cpu_req && wb_req;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_conf <= '0;
        end else if (conflict && (stat_conf != {STAT_W{1'b1}})) begin
            stat_conf <= stat_conf + 16'd1;
        end
    end
`else
    // The default build carries no statistics state.
`endif

endmodule

// File: tb/tb_hs32_sram_arbiter.sv
// Directed self-checking bench for hs32_sram_arbiter: one round-robin and one fixed-priority
// instance, each on its own behavioural SRAM word array.
module tb_hs32_sram_arbiter;
    import hs32_sram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;

    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [9:0]  cpu_addr  [2];
    logic [7:0]  cpu_dtw   [2];
    logic        cpu_ack   [2];
    logic [7:0]  cpu_dtr   [2];
    logic        wb_req    [2];
    logic        wb_we     [2];
    logic [9:0]  wb_addr   [2];
    logic [7:0]  wb_dtw    [2];
    logic        wb_ack    [2];
    logic [7:0]  wb_dtr    [2];
    logic        sram_we_n [2];
    logic [7:0]  sram_addr [2];
    logic [3:0]  sram_mask [2];
    logic [31:0] sram_dtw  [2];
    logic [31:0] sram_dtr  [2];
`ifdef HS32_SRAM_ARB_STATS_EN
    logic [15:0] stat_conf [2];
`endif

    logic [31:0] mem [2][256];
    bit          preloaded = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    int          cpu_ack_at [4];
    int          wb_ack_at  [4];
    int          r_lat;
    int          r_we_low;
    logic [7:0]  r_dtr;
    logic [7:0]  r_addr;
    logic [3:0]  r_mask;
    logic [31:0] r_din;

    always #5 clk = ~clk;

    hs32_sram_arbiter #(.AW(10), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_dtw(cpu_dtw[0]),
        .cpu_ack(cpu_ack[0]), .cpu_dtr(cpu_dtr[0]),
        .wb_req(wb_req[0]), .wb_we(wb_we[0]), .wb_addr(wb_addr[0]), .wb_dtw(wb_dtw[0]),
        .wb_ack(wb_ack[0]), .wb_dtr(wb_dtr[0]),
        .sram_we_n(sram_we_n[0]), .sram_addr(sram_addr[0]), .sram_mask(sram_mask[0]),
        .sram_dtw(sram_dtw[0]), .sram_dtr(sram_dtr[0])
`ifdef HS32_SRAM_ARB_STATS_EN
       ,.stat_conf(stat_conf[0])
`endif
    );

    hs32_sram_arbiter #(.AW(10), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_dtw(cpu_dtw[1]),
        .cpu_ack(cpu_ack[1]), .cpu_dtr(cpu_dtr[1]),
        .wb_req(wb_req[1]), .wb_we(wb_we[1]), .wb_addr(wb_addr[1]), .wb_dtw(wb_dtw[1]),
        .wb_ack(wb_ack[1]), .wb_dtr(wb_dtr[1]),
        .sram_we_n(sram_we_n[1]), .sram_addr(sram_addr[1]), .sram_mask(sram_mask[1]),
        .sram_dtw(sram_dtw[1]), .sram_dtr(sram_dtr[1])
`ifdef HS32_SRAM_ARB_STATS_EN
       ,.stat_conf(stat_conf[1])
`endif
    );

    // Synchronous SRAM: masked write and registered read on the same edge.
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int k = 0; k < 2; k++) begin
                for (int w = 0; w < 256; w++) mem[k][w] <= 32'h0;
                mem[k][8'h01] <= 32'h44332211;
                mem[k][8'h0C] <= 32'hDDCCBBAA;
                sram_dtr[k]   <= 32'h0;
            end
            preloaded <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!sram_we_n[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sram_mask[k][b]) mem[k][sram_addr[k]][8*b +: 8] <= sram_dtw[k][8*b +: 8];
                    end
                end
                sram_dtr[k] <= mem[k][sram_addr[k]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One access from one requester; starts and ends just after a rising edge with the arbiter idle.
    task automatic access(input int inst, input bit wb, input bit we,
                          input logic [9:0] addr, input logic [7:0] dtw);
        logic ack;
        if (wb) begin
            wb_we[inst] = we; wb_addr[inst] = addr; wb_dtw[inst] = dtw; wb_req[inst] = 1'b1;
        end else begin
            cpu_we[inst] = we; cpu_addr[inst] = addr; cpu_dtw[inst] = dtw; cpu_req[inst] = 1'b1;
        end
        r_lat = -1; r_we_low = 0; r_dtr = 8'h00;
        r_addr = 8'h00; r_mask = 4'h0; r_din = 32'h0;
        for (int i = 0; i < 10 && r_lat < 0; i++) begin
            @(negedge clk);
            if (!sram_we_n[inst]) r_we_low++;
            if (i == 1) begin
                r_addr = sram_addr[inst]; r_mask = sram_mask[inst]; r_din = sram_dtw[inst];
            end
            ack = wb ? wb_ack[inst] : cpu_ack[inst];
            if (ack) begin
                r_lat = i;
                r_dtr = wb ? wb_dtr[inst] : cpu_dtr[inst];
            end
        end
        @(posedge clk); #1;
        if (wb) wb_req[inst] = 1'b0;
        else    cpu_req[inst] = 1'b0;
        @(posedge clk); #1;
    endtask

    // Both requesters raise reads together; each holds req until it has collected n acks.
    task automatic duel(input int inst, input int cpu_n, input int wb_n);
        int  nc, nw;
        bit  dc, dw;
        for (int i = 0; i < 4; i++) begin cpu_ack_at[i] = -1; wb_ack_at[i] = -1; end
        cpu_we[inst] = 1'b0; cpu_addr[inst] = 10'h032; cpu_req[inst] = 1'b1;
        wb_we[inst]  = 1'b0; wb_addr[inst]  = 10'h004; wb_req[inst]  = 1'b1;
        nc = 0; nw = 0;
        for (int k = 0; k < 4 * (cpu_n + wb_n) + 4; k++) begin
            @(negedge clk);
            dc = 1'b0; dw = 1'b0;
            if (cpu_ack[inst] && nc < 4) begin
                cpu_ack_at[nc] = k; nc++;
                if (nc == cpu_n) dc = 1'b1;
            end
            if (wb_ack[inst] && nw < 4) begin
                wb_ack_at[nw] = k; nw++;
                if (nw == wb_n) dw = 1'b1;
            end
            @(posedge clk); #1;
            if (dc) cpu_req[inst] = 1'b0;
            if (dw) wb_req[inst]  = 1'b0;
        end
        cpu_req[inst] = 1'b0; wb_req[inst] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_dtw[k] = '0;
            wb_req[k]  = 1'b0; wb_we[k]  = 1'b0; wb_addr[k]  = '0; wb_dtw[k]  = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst cpu_ack",   32'(cpu_ack[0]),   32'h0);
        check("rst wb_ack",    32'(wb_ack[0]),    32'h0);
        check("rst we_n",      32'(sram_we_n[0]), 32'h1);
        check("rst sram_addr", 32'(sram_addr[0]), 32'h0);
        check("rst sram_mask", 32'(sram_mask[0]), 32'h0);
        check("rst sram_dtw",  sram_dtw[0],       32'h0);
        check("rst cpu_dtr",   32'(cpu_dtr[0]),   32'h0);
        check("rst state",     32'(dut_a.state),  32'(IDLE));
`ifdef HS32_SRAM_ARB_STATS_EN
        check("rst stat_conf", 32'(stat_conf[0]), 32'h0);
`endif

        // Round-robin: both requests pending as reset lifts; CPU wins the first tie.
        @(posedge clk); #1;
        rstn = 1'b1;
        duel(0, 2, 1);
        check("rr cpu ack0", 32'(cpu_ack_at[0]), 32'd3);
        check("rr wb ack0",  32'(wb_ack_at[0]),  32'd7);
        check("rr cpu ack1", 32'(cpu_ack_at[1]), 32'd11);
        check("rr wb_dtr",   32'(wb_dtr[0]),     32'h11);
`ifdef HS32_SRAM_ARB_STATS_EN
        check("rr stat_conf", 32'(stat_conf[0]), 32'd2);
`endif
        // CPU owned the port last, so the next tie goes to WB.
        duel(0, 1, 1);
        check("rr2 wb ack0",  32'(wb_ack_at[0]),  32'd3);
        check("rr2 cpu ack0", 32'(cpu_ack_at[0]), 32'd7);
        check("rr2 cpu_dtr",  32'(cpu_dtr[0]),    32'hCC);
`ifdef HS32_SRAM_ARB_STATS_EN
        check("rr2 stat_conf", 32'(stat_conf[0]), 32'd3);
`endif

        // Fixed priority: CPU keeps req high for three accesses, WB waits until CPU drops.
        duel(1, 3, 1);
        check("fp cpu ack0", 32'(cpu_ack_at[0]), 32'd3);
        check("fp cpu ack1", 32'(cpu_ack_at[1]), 32'd7);
        check("fp cpu ack2", 32'(cpu_ack_at[2]), 32'd11);
        check("fp wb ack0",  32'(wb_ack_at[0]),  32'd15);
`ifdef HS32_SRAM_ARB_STATS_EN
        check("fp stat_conf", 32'(stat_conf[1]), 32'd3);
`endif

        // Single CPU read of lane 2 in word 0x0C.
        access(0, 1'b0, 1'b0, 10'h032, 8'h00);
        check("rd latency",   32'(r_lat),    32'd3);
        check("rd sram_addr", 32'(r_addr),   32'h0C);
        check("rd sram_mask", 32'(r_mask),   32'b0100);
        check("rd we_n low",  32'(r_we_low), 32'd0);
        check("rd cpu_dtr",   32'(r_dtr),    32'hCC);

        // WB write of lane 3 in word 0x01.
        access(0, 1'b1, 1'b1, 10'h007, 8'h5A);
        check("wr latency",   32'(r_lat),    32'd3);
        check("wr we_n low",  32'(r_we_low), 32'd1);
        check("wr sram_addr", 32'(r_addr),   32'h01);
        check("wr sram_mask", 32'(r_mask),   32'b1000);
        check("wr sram_dtw",  r_din,         32'h5A5A5A5A);
        check("wr mem word",  mem[0][1],     32'h5A332211);
        check("wr wb_dtr held",  32'(wb_dtr[0]),  32'h11);
        check("wr cpu_dtr held", 32'(cpu_dtr[0]), 32'hCC);

        access(0, 1'b1, 1'b0, 10'h007, 8'h00);
        check("rb lane3", 32'(r_dtr), 32'h5A);
        access(0, 1'b0, 1'b0, 10'h006, 8'h00);
        check("rb lane2", 32'(r_dtr), 32'h33);
        access(0, 1'b0, 1'b0, 10'h005, 8'h00);
        check("rb lane1", 32'(r_dtr), 32'h22);
        access(0, 1'b1, 1'b0, 10'h004, 8'h00);
        check("rb lane0", 32'(r_dtr), 32'h11);

        // Reset asserted while the arbiter sits in WAIT.
        cpu_we[0] = 1'b0; cpu_addr[0] = 10'h032; cpu_req[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("mid state wait", 32'(dut_a.state), 32'(WAIT));
        rstn = 1'b0;
        #1;
        check("mid state",   32'(dut_a.state),  32'(IDLE));
        check("mid we_n",    32'(sram_we_n[0]), 32'h1);
        check("mid mask",    32'(sram_mask[0]), 32'h0);
        check("mid cpu_dtr", 32'(cpu_dtr[0]),   32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid cpu_ack", 32'(cpu_ack[0]), 32'h0);
            check("mid wb_ack",  32'(wb_ack[0]),  32'h0);
        end
`ifdef HS32_SRAM_ARB_STATS_EN
        check("mid stat_conf", 32'(stat_conf[0]), 32'h0);
`endif
        @(posedge clk); #1;
        rstn = 1'b1;
        access(0, 1'b0, 1'b0, 10'h032, 8'h00);
        check("post latency", 32'(r_lat), 32'd3);
        check("post cpu_dtr", 32'(r_dtr), 32'hCC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
